maj_vector_checker: RTL and testbench
=====================================

# maj_vector_checker

Self-checking stimulus and response stage for the N-input majority gate netlists. Drives an N-bit vector into the DUT's x0..x(N-1) inputs each cycle, and samples the DUT's y0 after a fixed latency. Compares y0 against an internal popcount-based majority reference and accumulates mismatches. Used on-chip and in FPGA bring-up, where exhaustive simulation of wide majority gates is impractical.

## Interface
- N, 61: DUT input width; odd, 3..64.
- DUT_LAT, 0: DUT latency in cycles from x_out to y_dut; 0 means combinational; range 0..7.
- SEED, 64'h1: LFSR seed. A value of 0 is replaced by 1.

- clk  in  1  single clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- start  in  1  one-cycle pulse that begins a run; ignored while busy=1.
- mode  in  1  sampled at start. 0 = exhaustive counter from 0; 1 = LFSR.
- num_vecs  in  32  number of vectors to issue; sampled at start.
- x_out  out  N  vector to DUT, registered.
- y_dut  in  1  DUT output y0.
- busy  out  1  high from the cycle after start until done.
- done  out  1  one-cycle pulse at the end of a run.
- pass  out  1  valid when done; held until the next accepted start.
- mismatch_cnt  out  16  mismatches in the current run; saturates at 16'hFFFF.
- first_fail_vec  out  N  first vector that mismatched.
- first_fail_valid  out  1  high once first_fail_vec is captured.

## Operation
- Reference: ref = (popcount(x_out) >= (N+1)/2). The popcount is 7 bits wide, so there is no overflow for N≤64.
- Generator, mode 0: counter k starting at 0. x_out = k[N-1:0], incrementing by 1 per issued vector and wrapping modulo 2^N.
- Generator, mode 1: 64-bit Galois LFSR with polynomial x^64+x^63+x^61+x^60+1, loaded with SEED at start.
  - x_out = lfsr[N-1:0]; the LFSR advances once per issued vector.
  - The first issued vector is the seed itself.
- Delay line: DUT_LAT+1 stages, each carrying {valid, ref, vector}, aligned so that each ref meets the y_dut its vector produced.
- Check rule: at each aligned valid slot, y_dut !== ref counts as a mismatch.
  - mismatch_cnt increments by 1, saturating.
  - On the first mismatch of a run, the vector is latched into first_fail_vec and first_fail_valid is set.
- FSM:
  - IDLE: outputs hold. start=1 clears mismatch_cnt, first_fail_valid and pass, loads the generator, and moves to RUN. If num_vecs=0, it moves to DONE instead.
  - RUN: issues one vector per cycle and decrements the remaining count. After the last vector is issued, moves to DRAIN.
  - DRAIN: waits DUT_LAT+1 cycles so that all in-flight vectors are checked, then moves to DONE.
  - DONE: done=1 for one cycle; pass = (mismatch_cnt==0); moves to IDLE.
- x_out holds its last issued value in IDLE, DRAIN and DONE. Only valid slots are checked.
- start arriving in the DONE cycle is ignored. start is accepted again from IDLE.

## Timing
- Reset values: x_out=0, busy=0, done=0, pass=0, mismatch_cnt=0, first_fail_vec=0, first_fail_valid=0, FSM=IDLE, delay line valid bits=0.
- Reset asserted mid-run: takes effect at the next rising edge. The run aborts with no done pulse, and all state returns to reset values.
- start accepted at edge e0: first vector appears on x_out after e0, in cycle c1. busy=1 from c1.
- Vector issued in cycle ci: y_dut is compared at the rising edge ending cycle ci+DUT_LAT.
- Run of V≥1 vectors: the last vector is in cycle cV and the done pulse is in cycle cV+DUT_LAT+2.
  - busy falls in the same cycle that done rises.
  - The total run is V+DUT_LAT+2 cycles from start.
- Run of V=0: done pulses in c1 with pass=1 and busy=0.
- Saturation: at mismatch_cnt=16'hFFFF, further mismatches leave the count unchanged and pass stays 0.

## Test plan
- N=5, DUT_LAT=0, mode 0, num_vecs=32, correct majority model:
  - x_out steps 0..31.
  - done in cycle 34 after start.
  - pass=1, mismatch_cnt=0, first_fail_valid=0.
- N=5, DUT_LAT=2, mode 0, num_vecs=32, model with output forced to 0 when input = 5'b00111:
  - mismatch_cnt=1, first_fail_vec=5'b00111, pass=0.
  - done in cycle 36.
- N=61, DUT_LAT=0, mode 1, SEED=1, num_vecs=1000, correct model:
  - first x_out = 61'h1.
  - pass=1 after 1002 cycles.
  - A golden LFSR sequence in the bench matches x_out cycle by cycle.
- N=61, mode 0, num_vecs=70000, model with y0 inverted:
  - mismatch_cnt saturates at 16'hFFFF.
  - first_fail_vec=0, pass=0.
- Boundary and reset checks:
  - num_vecs=0: done in c1 with pass=1.
  - start pulsed mid-run: ignored, count unaffected.
  - rst_n=0 for one cycle at vector 10 of 32: all outputs read reset values the next cycle, with no done pulse.
  - A fresh start after that reset completes with pass=1.

Source files
------------

// File: rtl/maj_vector_checker.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : maj_vector_checker
//  Purpose  : Stimulus/response checker for N-input majority gate netlists.
//             Issues one N-bit vector per cycle (counter or 64-bit Galois
//             LFSR), carries a popcount-based majority reference through a
//             delay line matched to the DUT latency, compares it against the
//             DUT's y0 and accumulates a saturating mismatch count.
//  Ports    : clk, rst_n (sync, active-low)
//             start/mode/num_vecs  run control, sampled when a start is taken
//             x_out                registered vector driven to the DUT
//             y_dut                DUT output y0
//             busy/done/pass       run status
//             mismatch_cnt         saturating mismatch count of current run
//             first_fail_vec/_valid  first mismatching vector of the run
//  Revision : 1.0  initial release
// ============================================================================
module maj_vector_checker #(
    parameter int unsigned N       = 61,
    parameter int unsigned DUT_LAT = 0,
    parameter logic [63:0] SEED    = 64'h1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         mode,
    input  logic [31:0]  num_vecs,
    output logic [N-1:0] x_out,
    input  logic         y_dut,
    output logic         busy,
    output logic         done,
    output logic         pass,
    output logic [15:0]  mismatch_cnt,
    output logic [N-1:0] first_fail_vec,
    output logic         first_fail_valid
);

    // An all-zero seed would lock the LFSR at zero.
    localparam logic [63:0] SEED_EFF   = (SEED == 64'd0) ? 64'd1 : SEED;
    // Right-shifting Galois taps for x^64+x^63+x^61+x^60+1.
    localparam logic [63:0] LFSR_TAPS  = 64'hD800_0000_0000_0000;
    localparam logic [6:0]  MAJ_THRESH = 7'((N + 1) / 2);
    localparam logic [2:0]  DRAIN_LOAD = 3'(DUT_LAT);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    function automatic logic [6:0] popcount(input logic [N-1:0] v);
        logic [6:0] c;
        c = '0;
        for (int i = 0; i < N; i++) begin
            c = c + 7'(v[i]);
        end
        return c;
    endfunction

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    logic [1:0]           state_q, state_d;
    logic [N-1:0]         x_out_q, x_out_d;
    logic [63:0]          gen_q, gen_d;
    logic                 mode_q, mode_d;
    logic [31:0]          rem_q, rem_d;
    logic [2:0]           drain_q, drain_d;
    logic [DUT_LAT:0]     vld_q, vld_d;
    logic [DUT_LAT:0]     ref_q, ref_d;
    logic [DUT_LAT:0][N-1:0] vec_q, vec_d;
    logic [15:0]          mm_cnt_q, mm_cnt_d;
    logic [N-1:0]         ff_vec_q, ff_vec_d;
    logic                 ff_valid_q, ff_valid_d;
    logic                 pass_q, pass_d;

    // Control strobes from the output decode.
    logic                 accept;
    logic                 issue;

    logic [63:0]          gen_src;
    logic [63:0]          gen_adv;
    logic                 mism;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = (num_vecs == 32'd0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (rem_q == 32'd0) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (drain_q == 3'd0) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: output decode
    // ------------------------------------------------------------------
    always_comb begin
        accept = (state_q == ST_IDLE) && start;
        // The first vector goes out on the accepting edge itself.
        issue  = (accept && (num_vecs != 32'd0)) ||
                 ((state_q == ST_RUN) && (rem_q != 32'd0));
        busy   = (state_q == ST_RUN) || (state_q == ST_DRAIN);
        done   = (state_q == ST_DONE);
    end

    // ------------------------------------------------------------------
    // Vector generator
    // ------------------------------------------------------------------
    always_comb begin
        mode_d  = accept ? mode : mode_q;
        gen_src = accept ? (mode ? SEED_EFF : 64'd0) : gen_q;
        gen_adv = mode_d ? ({1'b0, gen_src[63:1]} ^ (gen_src[0] ? LFSR_TAPS : 64'd0))
                         : (gen_src + 64'd1);
        gen_d   = issue ? gen_adv : gen_q;
        x_out_d = issue ? gen_src[N-1:0] : x_out_q;

        rem_d = rem_q;
        if (accept) begin
            rem_d = num_vecs - 32'd1;
        end else if (issue) begin
            rem_d = rem_q - 32'd1;
        end

        drain_d = drain_q;
        if ((state_q == ST_RUN) && (rem_q == 32'd0)) begin
            drain_d = DRAIN_LOAD;
        end else if ((state_q == ST_DRAIN) && (drain_q != 3'd0)) begin
            drain_d = drain_q - 3'd1;
        end
    end

    // ------------------------------------------------------------------
    // Delay line: stage 0 is loaded together with x_out, so stage k holds
    // the vector that was on x_out k cycles ago.
    // ------------------------------------------------------------------
    assign vld_d[0] = issue;
    assign ref_d[0] = (popcount(x_out_d) >= MAJ_THRESH);
    assign vec_d[0] = x_out_d;

    for (genvar gi = 1; gi <= DUT_LAT; gi++) begin : g_delay
        assign vld_d[gi] = vld_q[gi-1];
        assign ref_d[gi] = ref_q[gi-1];
        assign vec_d[gi] = vec_q[gi-1];
    end

    // ------------------------------------------------------------------
    // Checker and result bookkeeping
    // ------------------------------------------------------------------
    always_comb begin
        mism       = vld_q[DUT_LAT] && (y_dut !== ref_q[DUT_LAT]);
        mm_cnt_d   = mm_cnt_q;
        ff_vec_d   = ff_vec_q;
        ff_valid_d = ff_valid_q;
        pass_d     = pass_q;
        if (accept) begin
            mm_cnt_d   = 16'd0;
            ff_valid_d = 1'b0;
            // An empty run goes straight to DONE and trivially passes.
            pass_d     = (num_vecs == 32'd0);
        end else begin
            if (mism) begin
                if (mm_cnt_q != 16'hFFFF) begin
                    mm_cnt_d = mm_cnt_q + 16'd1;
                end
                if (!ff_valid_q) begin
                    ff_valid_d = 1'b1;
                    ff_vec_d   = vec_q[DUT_LAT];
                end
            end
            if ((state_q == ST_DRAIN) && (drain_q == 3'd0)) begin
                pass_d = (mm_cnt_d == 16'd0);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            x_out_q    <= '0;
            gen_q      <= '0;
            mode_q     <= 1'b0;
            rem_q      <= '0;
            drain_q    <= '0;
            vld_q      <= '0;
            ref_q      <= '0;
            vec_q      <= '0;
            mm_cnt_q   <= '0;
            ff_vec_q   <= '0;
            ff_valid_q <= 1'b0;
            pass_q     <= 1'b0;
        end else begin
            x_out_q    <= x_out_d;
            gen_q      <= gen_d;
            mode_q     <= mode_d;
            rem_q      <= rem_d;
            drain_q    <= drain_d;
            vld_q      <= vld_d;
            ref_q      <= ref_d;
            vec_q      <= vec_d;
            mm_cnt_q   <= mm_cnt_d;
            ff_vec_q   <= ff_vec_d;
            ff_valid_q <= ff_valid_d;
            pass_q     <= pass_d;
        end
    end

    assign x_out            = x_out_q;
    assign pass             = pass_q;
    assign mismatch_cnt     = mm_cnt_q;
    assign first_fail_vec   = ff_vec_q;
    assign first_fail_valid = ff_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_maj_vector_checker.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_maj_vector_checker
//  Purpose  : Directed self-checking bench. Three checker instances drive
//             behavioural majority models: A (N=5, lat 0, correct),
//             B (N=5, lat 2, forced 0 at 5'b00111), C (N=61, lat 0,
//             optionally inverted output).
//  Revision : 1.0  initial release
// ============================================================================
module tb_maj_vector_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    // Instance A
    logic        start_a, mode_a, y_a, busy_a, done_a, pass_a, ffv_a;
    logic [31:0] nv_a;
    logic [4:0]  x_a, ffvec_a;
    logic [15:0] mm_a;
    // Instance B
    logic        start_b, mode_b, y_b, busy_b, done_b, pass_b, ffv_b;
    logic [31:0] nv_b;
    logic [4:0]  x_b, ffvec_b;
    logic [15:0] mm_b;
    logic        b_p1 = 1'b0, b_p2 = 1'b0;
    // Instance C
    logic        start_c, mode_c, y_c, busy_c, done_c, pass_c, ffv_c;
    logic [31:0] nv_c;
    logic [60:0] x_c, ffvec_c;
    logic [15:0] mm_c;
    logic        inv_c;

    maj_vector_checker #(.N(5), .DUT_LAT(0), .SEED(64'h1)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .mode(mode_a), .num_vecs(nv_a),
        .x_out(x_a), .y_dut(y_a), .busy(busy_a), .done(done_a), .pass(pass_a),
        .mismatch_cnt(mm_a), .first_fail_vec(ffvec_a), .first_fail_valid(ffv_a));

    maj_vector_checker #(.N(5), .DUT_LAT(2), .SEED(64'h1)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .mode(mode_b), .num_vecs(nv_b),
        .x_out(x_b), .y_dut(y_b), .busy(busy_b), .done(done_b), .pass(pass_b),
        .mismatch_cnt(mm_b), .first_fail_vec(ffvec_b), .first_fail_valid(ffv_b));

    maj_vector_checker #(.N(61), .DUT_LAT(0), .SEED(64'h1)) u_dut_c (
        .clk(clk), .rst_n(rst_n), .start(start_c), .mode(mode_c), .num_vecs(nv_c),
        .x_out(x_c), .y_dut(y_c), .busy(busy_c), .done(done_c), .pass(pass_c),
        .mismatch_cnt(mm_c), .first_fail_vec(ffvec_c), .first_fail_valid(ffv_c));

    // Majority gate models
    assign y_a = ($countones(x_a) >= 3);
    always @(posedge clk) begin
        b_p1 <= (x_b == 5'b00111) ? 1'b0 : ($countones(x_b) >= 3);
        b_p2 <= b_p1;
    end
    assign y_b = b_p2;
    assign y_c = ($countones(x_c) >= 31) ^ inv_c;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [63:0] lfsr_step(input logic [63:0] s);
        logic [63:0] t;
        t = {1'b0, s[63:1]};
        if (s[0]) begin
            t[63] = ~t[63];
            t[62] = ~t[62];
            t[60] = ~t[60];
            t[59] = ~t[59];
        end
        return t;
    endfunction

    int          done_cyc;
    int          done_pulses;
    logic        pass_at, busy_at, ffv_at;
    logic [15:0] mm_at;
    logic [63:0] ffvec_at;
    logic [63:0] golden;

    initial begin
        rst_n = 1'b0;
        start_a = 0; mode_a = 0; nv_a = 0;
        start_b = 0; mode_b = 0; nv_b = 0;
        start_c = 0; mode_c = 0; nv_c = 0; inv_c = 0;
        repeat (3) @(negedge clk);

        // ---------------- Reset state ----------------
        check("rst_x",     64'(x_a), 0);
        check("rst_busy",  64'(busy_a), 0);
        check("rst_done",  64'(done_a), 0);
        check("rst_pass",  64'(pass_a), 0);
        check("rst_mm",    64'(mm_a), 0);
        check("rst_ffv",   64'(ffv_a), 0);
        check("rst_ffvec", 64'(ffvec_a), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // ---------------- A: exhaustive 32, ignored mid-run start ----------------
        start_a = 1; mode_a = 0; nv_a = 32;
        @(posedge clk); @(negedge clk);
        done_cyc = 0;
        for (int c = 1; c <= 40; c++) begin
            start_a = (c == 10);
            if (c == 1) check("a_busy_c1", 64'(busy_a), 1);
            if (c <= 32) check("a_x_seq", 64'(x_a), 64'(c - 1));
            if (done_a && done_cyc == 0) begin
                done_cyc = c; pass_at = pass_a; mm_at = mm_a; ffv_at = ffv_a; busy_at = busy_a;
            end
            @(negedge clk);
        end
        start_a = 0;
        check("a_done_cyc", 64'(done_cyc), 34);
        check("a_pass", 64'(pass_at), 1);
        check("a_mm", 64'(mm_at), 0);
        check("a_ffv", 64'(ffv_at), 0);
        check("a_busy_at_done", 64'(busy_at), 0);
        check("a_x_hold", 64'(x_a), 31);

        // ---------------- B: latency 2, faulty at 00111 ----------------
        start_b = 1; mode_b = 0; nv_b = 32;
        @(posedge clk); @(negedge clk);
        start_b = 0;
        done_cyc = 0;
        for (int c = 1; c <= 45; c++) begin
            if (done_b && done_cyc == 0) begin
                done_cyc = c; pass_at = pass_b; mm_at = mm_b; ffv_at = ffv_b; ffvec_at = 64'(ffvec_b);
            end
            @(negedge clk);
        end
        check("b_done_cyc", 64'(done_cyc), 36);
        check("b_mm", 64'(mm_at), 1);
        check("b_ffvec", ffvec_at, 64'h7);
        check("b_ffv", 64'(ffv_at), 1);
        check("b_pass", 64'(pass_at), 0);

        // ---------------- B: empty run ----------------
        start_b = 1; nv_b = 0;
        @(posedge clk); @(negedge clk);
        start_b = 0;
        check("b_v0_done", 64'(done_b), 1);
        check("b_v0_pass", 64'(pass_b), 1);
        check("b_v0_busy", 64'(busy_b), 0);
        check("b_v0_mm",   64'(mm_b), 0);
        @(negedge clk);
        check("b_v0_done_pulse", 64'(done_b), 0);

        // ---------------- A: reset at vector 10 ----------------
        start_a = 1; nv_a = 32;
        @(posedge clk); @(negedge clk);
        start_a = 0;
        repeat (9) @(negedge clk);
        check("a_pre_rst_x", 64'(x_a), 9);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("mid_rst_x",    64'(x_a), 0);
        check("mid_rst_busy", 64'(busy_a), 0);
        check("mid_rst_done", 64'(done_a), 0);
        check("mid_rst_pass", 64'(pass_a), 0);
        check("mid_rst_mm",   64'(mm_a), 0);
        check("mid_rst_ffv",  64'(ffv_a), 0);
        done_pulses = 0;
        for (int c = 0; c < 40; c++) begin
            if (done_a) done_pulses++;
            @(negedge clk);
        end
        check("mid_rst_no_done", 64'(done_pulses), 0);

        // ---------------- A: fresh start after reset ----------------
        start_a = 1; nv_a = 32;
        @(posedge clk); @(negedge clk);
        start_a = 0;
        done_cyc = 0; pass_at = 0;
        for (int c = 1; c <= 40; c++) begin
            if (done_a && done_cyc == 0) begin done_cyc = c; pass_at = pass_a; end
            @(negedge clk);
        end
        check("a2_done_cyc", 64'(done_cyc), 34);
        check("a2_pass", 64'(pass_at), 1);

        // ---------------- C: LFSR 1000 vectors ----------------
        start_c = 1; mode_c = 1; nv_c = 1000; inv_c = 0;
        @(posedge clk); @(negedge clk);
        start_c = 0;
        check("c_first_x", 64'(x_c), 64'h1);
        golden = 64'h1;
        done_cyc = 0; pass_at = 0; mm_at = 16'hDEAD;
        for (int c = 1; c <= 1010; c++) begin
            if (c <= 1000) begin
                check("c_lfsr_x", 64'(x_c), 64'(golden[60:0]));
                golden = lfsr_step(golden);
            end
            if (done_c && done_cyc == 0) begin done_cyc = c; pass_at = pass_c; mm_at = mm_c; end
            @(negedge clk);
        end
        check("c_done_cyc", 64'(done_cyc), 1002);
        check("c_pass", 64'(pass_at), 1);
        check("c_mm", 64'(mm_at), 0);

        // ---------------- C: saturation with inverted model ----------------
        start_c = 1; mode_c = 0; nv_c = 70000; inv_c = 1;
        @(posedge clk); @(negedge clk);
        start_c = 0;
        done_cyc = 0; pass_at = 1; mm_at = 0; ffv_at = 0; ffvec_at = '1;
        for (int c = 1; c <= 70010; c++) begin
            if (done_c && done_cyc == 0) begin
                done_cyc = c; pass_at = pass_c; mm_at = mm_c; ffv_at = ffv_c; ffvec_at = 64'(ffvec_c);
            end
            @(negedge clk);
        end
        check("sat_done_cyc", 64'(done_cyc), 70002);
        check("sat_mm", 64'(mm_at), 64'hFFFF);
        check("sat_ffvec", ffvec_at, 0);
        check("sat_ffv", 64'(ffv_at), 1);
        check("sat_pass", 64'(pass_at), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
